multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with ready handshakes to instruction memory, data memory and an optional multi-cycle mul/div unit. It also detects illegal instructions and data-bus timeouts and raises a trap. It sits between the instruction register and the datapath, and drives every datapath enable and mux select.

Parameters:
M_EXT, 0, 1 = decode RV32M (OP_REG with funct7=0000001) into the MULDIV path; 0 = such encodings are illegal
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for dmem_ready before a bus-error trap; 0 = no timeout
TRAP_EN, 1, 1 = illegal/bus-error go to TRAP; 0 = treated as NOP (return to FETCH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  7  instruction register [6:0]
funct3  in  3  instruction register [14:12]
funct7  in  7  instruction register [31:25]
imem_ready  in  1  fetched instruction valid this cycle
dmem_ready  in  1  data access complete this cycle
muldiv_done  in  1  mul/div result valid
branch_taken  in  1  datapath comparison result (alu_ctrl=ALU_B*)
pc_write  out  1  PC update enable
pc_src  out  2  0=PC+4, 1=branch/jump target, 2=trap vector
ir_write  out  1  latch instruction register
reg_write  out  1  register-file write enable
mem_read  out  1  data read request (held until dmem_ready)
mem_write  out  1  data write request (held until dmem_ready)
alu_src  out  1  1 = immediate operand
mem_to_reg  out  2  riscv_pkg MEM_TO_REG_ALU/MEM/PC4; 2'b11 = mul/div result
alu_ctrl  out  4  riscv_pkg ALU_* encoding
lui_instr, auipc_instr  out  1 each  operand-A overrides
muldiv_start  out  1  one-cycle start pulse
muldiv_op  out  3  funct3 of the M instruction
trap  out  1  one-cycle trap pulse
trap_cause  out  2  0=none, 1=illegal, 2=bus timeout
busy  out  1  high in every state except FETCH

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, MULDIV, WRITEBACK, TRAP.
- rst (sync): state=FETCH, all outputs 0, timeout counter 0, latched decode cleared. Reset mid-MEM/MULDIV drops the request immediately with no pulse.
- FETCH: ir_write=1. When imem_ready=1, pc_write=1 with pc_src=0 and go to DECODE; otherwise stay.
- DECODE: latch alu_ctrl/alu_src/mem_to_reg/lui/auipc/class. Decode rules per opcode follow riscv_pkg (SUB/SRA/SRAI via FUNCT7_ALT, branches to ALU_BEQ..BGEU).
- DECODE transitions: FENCE (0001111) → FETCH. Unknown opcode, or funct7=0000001 with M_EXT=0 → TRAP (cause 1). Otherwise → EXECUTE.
- EXECUTE, by class:
  - ALU/LUI/AUIPC → WRITEBACK.
  - LOAD/STORE → MEM.
  - BRANCH: pc_write=branch_taken, pc_src=1, then → FETCH.
  - JAL/JALR: pc_write=1, pc_src=1, then → WRITEBACK.
  - M-ext: muldiv_start=1 for exactly one cycle, then → MULDIV.
- MEM: mem_read (load) or mem_write (store) held steady.
  - dmem_ready=1: load → WRITEBACK, store → FETCH.
  - Counter increments each waiting cycle. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without dmem_ready, drop the request and go to TRAP (cause 2).
  - dmem_ready on the same cycle the counter hits the limit counts as success.
  - Counter clears on MEM exit.
- MULDIV: wait for muldiv_done, then → WRITEBACK with mem_to_reg=2'b11. No timeout.
- WRITEBACK: reg_write=1 for exactly one cycle → FETCH.
- TRAP: trap=1, trap_cause valid, pc_write=1, pc_src=2, reg_write=0 → FETCH. With TRAP_EN=0, DECODE/MEM go to FETCH instead: no trap, no writes.
- Data outputs (alu_ctrl etc.) hold their latched value from DECODE until the next DECODE. Enable/strobe outputs (pc_write, ir_write, reg_write, mem_*, muldiv_start, trap) are 0 outside the states listed above.
- Latency with all readies=1:
  - R/I-type, LUI, AUIPC, JAL, JALR, store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - FENCE: 2 cycles.
  - M-ext: 4 cycles + MULDIV wait.

Test Plan:
- Reset: rst=1 during MEM with mem_read=1 → next cycle state=FETCH, mem_read=0, all strobes 0, busy=0.
- ADD then SUB (opcode 0110011, funct7 0000000/0100000), readies=1 → alu_ctrl=ALU_ADD then ALU_SUB; reg_write pulses on cycles 4 and 8; pc_write pulses in each FETCH.
- LW with dmem_ready delayed 3 cycles → mem_read high for 4 cycles, then WRITEBACK with mem_to_reg=MEM_TO_REG_MEM, reg_write=1 for one cycle. Total 8 cycles.
- SW with MEM_TIMEOUT=4 and dmem_ready never asserted → mem_write high 4 cycles, then trap=1, trap_cause=2, pc_src=2, no reg_write. Repeat with dmem_ready on cycle 4 → no trap.
- BEQ with branch_taken=1 and =0 → pc_write in EXECUTE only when taken (pc_src=1); 3-cycle turnaround both ways; reg_write never set.
- MUL (funct7 0000001): M_EXT=1 → muldiv_start single pulse, muldiv_op=000, and a 5-cycle muldiv_done wait stalls; then reg_write with mem_to_reg=2'b11. M_EXT=0 → trap_cause=1 from DECODE.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/MULDIV/WRITEBACK and raises traps for
// illegal encodings and data-bus timeouts.
module multicycle_control_unit #(
  parameter int M_EXT       = 0,
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_EN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       muldiv_done,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic [1:0] mem_to_reg,
  output logic [3:0] alu_ctrl,
  output logic       lui_instr,
  output logic       auipc_instr,
  output logic       muldiv_start,
  output logic [2:0] muldiv_op,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       busy
);

  // FSM state encodings
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_MULDIV    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;

  // Instruction classes latched in DECODE
  localparam logic [2:0] C_ALU     = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_STORE   = 3'd2;
  localparam logic [2:0] C_BRANCH  = 3'd3;
  localparam logic [2:0] C_JUMP    = 3'd4;
  localparam logic [2:0] C_MULDIV  = 3'd5;
  localparam logic [2:0] C_FENCE   = 3'd6;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  // Opcodes
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  // Write-back source selects
  localparam logic [1:0] MEM_TO_REG_ALU    = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM    = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC4    = 2'd2;
  localparam logic [1:0] MEM_TO_REG_MULDIV = 2'd3;

  // PC source selects and trap causes
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_TRAP   = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  // Counter only has to reach MEM_TIMEOUT-1
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  logic [2:0] r_class;
  logic [3:0] r_alu_ctrl;
  logic       r_alu_src;
  logic [1:0] r_mem_to_reg;
  logic       r_lui;
  logic       r_auipc;
  logic [2:0] r_muldiv_op;
  logic [1:0] r_cause;

  logic [2:0] w_class;
  logic [3:0] w_alu_ctrl;
  logic       w_alu_src;
  logic [1:0] w_mem_to_reg;
  logic       w_lui;
  logic       w_auipc;

  function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] f_branch_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b001:  op = ALU_BNE;
      3'b100:  op = ALU_BLT;
      3'b101:  op = ALU_BGE;
      3'b110:  op = ALU_BLTU;
      3'b111:  op = ALU_BGEU;
      default: op = ALU_BEQ;
    endcase
    return op;
  endfunction

  // Instruction decode from the instruction register fields
  always_comb begin
    w_class      = C_ALU;
    w_alu_ctrl   = ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_to_reg = MEM_TO_REG_ALU;
    w_lui        = 1'b0;
    w_auipc      = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == FUNCT7_MULDIV) begin
          w_class      = (M_EXT != 0) ? C_MULDIV : C_ILLEGAL;
          w_mem_to_reg = MEM_TO_REG_MULDIV;
        end else begin
          w_alu_ctrl = f_alu_op(funct3, funct7[5]);
        end
      end
      OP_IMM: begin
        w_alu_src  = 1'b1;
        // only the shift-right immediate uses funct7 as an alternate select
        w_alu_ctrl = f_alu_op(funct3, funct7[5] && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        w_class      = C_LOAD;
        w_alu_src    = 1'b1;
        w_mem_to_reg = MEM_TO_REG_MEM;
      end
      OP_STORE: begin
        w_class   = C_STORE;
        w_alu_src = 1'b1;
      end
      OP_BRANCH: begin
        w_class    = C_BRANCH;
        w_alu_ctrl = f_branch_op(funct3);
      end
      OP_LUI: begin
        w_alu_src = 1'b1;
        w_lui     = 1'b1;
      end
      OP_AUIPC: begin
        w_alu_src = 1'b1;
        w_auipc   = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        w_class      = C_JUMP;
        w_alu_src    = 1'b1;
        w_mem_to_reg = MEM_TO_REG_PC4;
      end
      OP_FENCE: w_class = C_FENCE;
      default:  w_class = C_ILLEGAL;
    endcase
  end

  // Bus timeout: a ready on the limit cycle still wins
  always_comb begin
    w_timeout = (MEM_TIMEOUT != 0) && !dmem_ready &&
                (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_nxt = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_class == C_FENCE)
          w_state_nxt = S_FETCH;
        else if (w_class == C_ILLEGAL)
          w_state_nxt = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
        else
          w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (r_class)
          C_LOAD, C_STORE: w_state_nxt = S_MEM;
          C_BRANCH:        w_state_nxt = S_FETCH;
          C_MULDIV:        w_state_nxt = S_MULDIV;
          default:         w_state_nxt = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)
          w_state_nxt = (r_class == C_LOAD) ? S_WRITEBACK : S_FETCH;
        else if (w_timeout)
          w_state_nxt = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
        else
          w_state_nxt = S_MEM;
      end
      S_MULDIV:    w_state_nxt = muldiv_done ? S_WRITEBACK : S_MULDIV;
      S_WRITEBACK: w_state_nxt = S_FETCH;
      S_TRAP:      w_state_nxt = S_FETCH;
      default:     w_state_nxt = S_FETCH;
    endcase
  end

  // State, wait counter, trap cause and latched decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_cnt        <= '0;
      r_class      <= C_ALU;
      r_alu_ctrl   <= '0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= '0;
      r_lui        <= 1'b0;
      r_auipc      <= 1'b0;
      r_muldiv_op  <= '0;
      r_cause      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_MEM) && (w_state_nxt == S_MEM) && (MEM_TIMEOUT != 0))
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
      if (w_state_nxt == S_TRAP)
        r_cause <= (r_state == S_MEM) ? CAUSE_BUS : CAUSE_ILLEGAL;
      if (r_state == S_DECODE) begin
        r_class      <= w_class;
        r_alu_ctrl   <= w_alu_ctrl;
        r_alu_src    <= w_alu_src;
        r_mem_to_reg <= w_mem_to_reg;
        r_lui        <= w_lui;
        r_auipc      <= w_auipc;
        r_muldiv_op  <= funct3;
      end
    end
  end

  // Output decode; rst gates everything so a pending request drops at once
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = PC_SEQ;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = '0;
    alu_ctrl     = '0;
    lui_instr    = 1'b0;
    auipc_instr  = 1'b0;
    muldiv_start = 1'b0;
    muldiv_op    = '0;
    trap         = 1'b0;
    trap_cause   = '0;
    busy         = 1'b0;
    if (!rst) begin
      busy        = (r_state != S_FETCH);
      alu_src     = r_alu_src;
      mem_to_reg  = r_mem_to_reg;
      alu_ctrl    = r_alu_ctrl;
      lui_instr   = r_lui;
      auipc_instr = r_auipc;
      muldiv_op   = r_muldiv_op;
      case (r_state)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = imem_ready;
        end
        S_EXECUTE: begin
          case (r_class)
            C_BRANCH: begin
              pc_write = branch_taken;
              pc_src   = PC_TARGET;
            end
            C_JUMP: begin
              pc_write = 1'b1;
              pc_src   = PC_TARGET;
            end
            C_MULDIV: muldiv_start = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          mem_read  = (r_class == C_LOAD);
          mem_write = (r_class == C_STORE);
        end
        S_WRITEBACK: reg_write = 1'b1;
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = r_cause;
          pc_write   = 1'b1;
          pc_src     = PC_TRAP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Instance u_dut has the M
// extension and a 4-cycle bus timeout; u_dut_nom lacks the M extension.
// Strobe vectors are {pc_write, ir_write, reg_write, mem_read,
// mem_write, muldiv_start, trap, busy}.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       imem_ready, dmem_ready, muldiv_done, branch_taken;

  logic       a_pc_write, a_ir_write, a_reg_write, a_mem_read, a_mem_write;
  logic       a_alu_src, a_lui, a_auipc, a_muldiv_start, a_trap, a_busy;
  logic [1:0] a_pc_src, a_mem_to_reg, a_trap_cause;
  logic [3:0] a_alu_ctrl;
  logic [2:0] a_muldiv_op;

  logic       b_pc_write, b_ir_write, b_reg_write, b_mem_read, b_mem_write;
  logic       b_alu_src, b_lui, b_auipc, b_muldiv_start, b_trap, b_busy;
  logic [1:0] b_pc_src, b_mem_to_reg, b_trap_cause;
  logic [3:0] b_alu_ctrl;
  logic [2:0] b_muldiv_op;

  logic [7:0] st_a, st_b;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign st_a = {a_pc_write, a_ir_write, a_reg_write, a_mem_read,
                 a_mem_write, a_muldiv_start, a_trap, a_busy};
  assign st_b = {b_pc_write, b_ir_write, b_reg_write, b_mem_read,
                 b_mem_write, b_muldiv_start, b_trap, b_busy};

  multicycle_control_unit #(.M_EXT(1), .MEM_TIMEOUT(4), .TRAP_EN(1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_done(muldiv_done), .branch_taken(branch_taken),
    .pc_write(a_pc_write), .pc_src(a_pc_src), .ir_write(a_ir_write),
    .reg_write(a_reg_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .alu_src(a_alu_src), .mem_to_reg(a_mem_to_reg), .alu_ctrl(a_alu_ctrl),
    .lui_instr(a_lui), .auipc_instr(a_auipc), .muldiv_start(a_muldiv_start),
    .muldiv_op(a_muldiv_op), .trap(a_trap), .trap_cause(a_trap_cause),
    .busy(a_busy)
  );

  multicycle_control_unit #(.M_EXT(0), .MEM_TIMEOUT(4), .TRAP_EN(1)) u_dut_nom (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_done(muldiv_done), .branch_taken(branch_taken),
    .pc_write(b_pc_write), .pc_src(b_pc_src), .ir_write(b_ir_write),
    .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .alu_src(b_alu_src), .mem_to_reg(b_mem_to_reg), .alu_ctrl(b_alu_ctrl),
    .lui_instr(b_lui), .auipc_instr(b_auipc), .muldiv_start(b_muldiv_start),
    .muldiv_op(b_muldiv_op), .trap(b_trap), .trap_cause(b_trap_cause),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, 32'(st_a), 32'(exp));
  endtask

  task automatic cyc(input string tag, input logic [7:0] exp);
    samp(tag, exp);
    adv();
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0; branch_taken = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0);
    adv();
    adv();
    @(negedge clk);
    check("rst_strobes", 32'(st_a), 32'h00);
    check("rst_strobes_nom", 32'(st_b), 32'h00);
    check("rst_pc_src", 32'(a_pc_src), 32'd0);
    adv();
    rst = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;

    // ADD then SUB: reg_write on cycles 4 and 8
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    samp("add_fetch", 8'hC0);
    check("add_fetch_pc_src", 32'(a_pc_src), 32'd0);
    adv();
    cyc("add_decode", 8'h01);
    cyc("add_exec", 8'h01);
    samp("add_wb", 8'h21);
    check("add_alu_ctrl", 32'(a_alu_ctrl), 32'd0);
    check("add_mem_to_reg", 32'(a_mem_to_reg), 32'd0);
    check("add_alu_src", 32'(a_alu_src), 32'd0);
    adv();
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    cyc("sub_fetch", 8'hC0);
    cyc("sub_decode", 8'h01);
    samp("sub_exec", 8'h01);
    check("sub_alu_ctrl", 32'(a_alu_ctrl), 32'd1);
    adv();
    cyc("sub_wb", 8'h21);

    // LW with dmem_ready on the 4th MEM cycle: 8 cycles total
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    dmem_ready = 1'b0;
    cyc("lw_fetch", 8'hC0);
    cyc("lw_decode", 8'h01);
    cyc("lw_exec", 8'h01);
    cyc("lw_mem1", 8'h11);
    cyc("lw_mem2", 8'h11);
    cyc("lw_mem3", 8'h11);
    dmem_ready = 1'b1;
    cyc("lw_mem4", 8'h11);
    samp("lw_wb", 8'h21);
    check("lw_mem_to_reg", 32'(a_mem_to_reg), 32'd1);
    check("lw_alu_src", 32'(a_alu_src), 32'd1);
    adv();

    // SW with no dmem_ready: 4 MEM cycles then bus-timeout trap
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    dmem_ready = 1'b0;
    cyc("sw_fetch", 8'hC0);
    cyc("sw_decode", 8'h01);
    cyc("sw_exec", 8'h01);
    for (int i = 0; i < 4; i++) cyc("sw_mem", 8'h09);
    samp("sw_trap", 8'h83);
    check("sw_trap_cause", 32'(a_trap_cause), 32'd2);
    check("sw_trap_pc_src", 32'(a_pc_src), 32'd2);
    adv();

    // Same SW, ready arrives on the limit cycle: completes without trap
    cyc("sw2_fetch", 8'hC0);
    cyc("sw2_decode", 8'h01);
    cyc("sw2_exec", 8'h01);
    for (int i = 0; i < 3; i++) cyc("sw2_mem", 8'h09);
    dmem_ready = 1'b1;
    cyc("sw2_mem4", 8'h09);

    // BEQ taken: PC written in EXECUTE, 3-cycle turnaround
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    branch_taken = 1'b1;
    cyc("sw2_done_fetch", 8'hC0);
    cyc("beq_decode", 8'h01);
    samp("beq_exec", 8'h81);
    check("beq_pc_src", 32'(a_pc_src), 32'd1);
    check("beq_alu_ctrl", 32'(a_alu_ctrl), 32'd10);
    adv();

    // BGE not taken: no PC write, still 3 cycles
    set_instr(7'b1100011, 3'b101, 7'b0000000);
    branch_taken = 1'b0;
    cyc("bge_fetch", 8'hC0);
    cyc("bge_decode", 8'h01);
    samp("bge_exec", 8'h01);
    check("bge_pc_src", 32'(a_pc_src), 32'd1);
    check("bge_alu_ctrl", 32'(a_alu_ctrl), 32'd13);
    adv();

    // JAL: target write in EXECUTE, link via PC+4
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    cyc("jal_fetch", 8'hC0);
    cyc("jal_decode", 8'h01);
    cyc("jal_exec", 8'h81);
    samp("jal_wb", 8'h21);
    check("jal_mem_to_reg", 32'(a_mem_to_reg), 32'd2);
    adv();

    // Reset while a load waits in MEM
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    dmem_ready = 1'b0;
    cyc("lwr_fetch", 8'hC0);
    cyc("lwr_decode", 8'h01);
    cyc("lwr_exec", 8'h01);
    samp("lwr_mem", 8'h11);
    rst = 1'b1;
    #1;
    check("rst_drops_mem_read", 32'(a_mem_read), 32'd0);
    adv();
    samp("rst_mid_strobes", 8'h00);
    check("rst_mid_mem_to_reg", 32'(a_mem_to_reg), 32'd0);
    check("rst_mid_strobes_nom", 32'(st_b), 32'h00);
    adv();
    rst = 1'b0;
    dmem_ready = 1'b1;

    // MUL: start pulse, 5-cycle wait, write-back of the mul/div result
    set_instr(7'b0110011, 3'b000, 7'b0000001);
    samp("mul_fetch", 8'hC0);
    check("nom_mul_fetch", 32'(st_b), 32'hC0);
    adv();
    samp("mul_decode", 8'h01);
    check("nom_mul_decode", 32'(st_b), 32'h01);
    adv();
    samp("mul_exec", 8'h05);
    check("mul_op", 32'(a_muldiv_op), 32'd0);
    check("nom_mul_trap", 32'(st_b), 32'h83);
    check("nom_mul_trap_cause", 32'(b_trap_cause), 32'd1);
    check("nom_mul_pc_src", 32'(b_pc_src), 32'd2);
    adv();
    for (int i = 0; i < 4; i++) cyc("mul_wait", 8'h01);
    muldiv_done = 1'b1;
    cyc("mul_wait5", 8'h01);
    muldiv_done = 1'b0;
    samp("mul_wb", 8'h21);
    check("mul_mem_to_reg", 32'(a_mem_to_reg), 32'd3);
    adv();

    // DIVU with immediate done: muldiv_op follows funct3
    set_instr(7'b0110011, 3'b101, 7'b0000001);
    muldiv_done = 1'b1;
    cyc("divu_fetch", 8'hC0);
    cyc("divu_decode", 8'h01);
    samp("divu_exec", 8'h05);
    check("divu_op", 32'(a_muldiv_op), 32'd5);
    adv();
    cyc("divu_wait", 8'h01);
    cyc("divu_wb", 8'h21);
    samp("divu_done_fetch", 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
